// File: rtl/wired_rob_ptr.sv
// ROB allocation/retire pointer manager: dispatch-side tail, commit-side head,
// occupancy count and the flush drain sequence (NORMAL/DRAIN).
module wired_rob_ptr #(
  parameter int ROB_LEN = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              alloc_req_i,
  output logic                    alloc_ready_o,
  output logic [1:0][ROB_LEN-1:0] alloc_rid_o,
  output logic [ROB_LEN:0]        tail_ptr_o,
  input  logic [1:0]              retire_i,
  output logic [1:0][ROB_LEN-1:0] c_rrrid_o,
  output logic [ROB_LEN:0]        head_ptr_o,
  output logic [1:0]              head_valid_o,
  output logic [ROB_LEN:0]        count_o,
  output logic                    empty_o,
  output logic                    full_o,
  input  logic                    flush_i,
  output logic                    draining_o
);

  // Handshake: alloc_ready_o is a function of registered state and flush_i only;
  // an allocation happens for each requested slot in a cycle where ready is 1.

  localparam logic [ROB_LEN:0] DEPTH_W = (ROB_LEN+1)'(1) << ROB_LEN;

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ROB_LEN:0] head_q, head_d;
  logic [ROB_LEN:0] tail_q, tail_d;
  logic [ROB_LEN:0] count_q, count_d;
  logic [ROB_LEN:0] free_w;
  logic [1:0]       n_req, n_ret_raw, n_alloc, n_retire;

  always_comb begin
    free_w        = DEPTH_W - count_q;
    alloc_ready_o = (state_q == NORMAL) && !flush_i && (free_w >= (ROB_LEN+1)'(2));
    n_req         = {1'b0, alloc_req_i[1]} + {1'b0, alloc_req_i[0]};
    n_ret_raw     = {1'b0, retire_i[1]} + {1'b0, retire_i[0]};
    n_alloc       = alloc_ready_o ? n_req : 2'd0;
    // Retires beyond the occupancy are dropped; count_q <= 1 in that case.
    if ({{(ROB_LEN-1){1'b0}}, n_ret_raw} > count_q) n_retire = count_q[1:0];
    else                                            n_retire = n_ret_raw;
    tail_d  = tail_q + {{(ROB_LEN-1){1'b0}}, n_alloc};
    head_d  = head_q + {{(ROB_LEN-1){1'b0}}, n_retire};
    count_d = count_q + {{(ROB_LEN-1){1'b0}}, n_alloc} - {{(ROB_LEN-1){1'b0}}, n_retire};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (flush_i) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    alloc_rid_o[0] = tail_q[ROB_LEN-1:0];
    alloc_rid_o[1] = tail_q[ROB_LEN-1:0] + ROB_LEN'(1);
    c_rrrid_o[0]   = head_q[ROB_LEN-1:0];
    c_rrrid_o[1]   = head_q[ROB_LEN-1:0] + ROB_LEN'(1);
    tail_ptr_o     = tail_q;
    head_ptr_o     = head_q;
    count_o        = count_q;
    head_valid_o   = {count_q >= (ROB_LEN+1)'(2), count_q != '0};
    empty_o        = (count_q == '0);
    full_o         = (count_q == DEPTH_W);
    draining_o     = (state_q == DRAIN);
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert ({{(ROB_LEN-1){1'b0}}, n_ret_raw} <= count_q)
        else $info("wired_rob_ptr: retire beyond occupancy ignored");
      assert (alloc_req_i != 2'b10)
        else $info("wired_rob_ptr: non-prefix alloc request");
      assert (retire_i != 2'b10)
        else $info("wired_rob_ptr: non-prefix retire");
    end
  end
`endif

endmodule

// File: tb/tb_wired_rob_ptr.sv
// Directed and random stimulus for wired_rob_ptr against an in-order id queue model.
module tb_wired_rob_ptr;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       alloc_req_i = '0;
  logic             alloc_ready_o;
  logic [1:0][5:0]  alloc_rid_o;
  logic [6:0]       tail_ptr_o;
  logic [1:0]       retire_i = '0;
  logic [1:0][5:0]  c_rrrid_o;
  logic [6:0]       head_ptr_o;
  logic [1:0]       head_valid_o;
  logic [6:0]       count_o;
  logic             empty_o;
  logic             full_o;
  logic             flush_i = 1'b0;
  logic             draining_o;

  wired_rob_ptr #(.ROB_LEN(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_i(alloc_req_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rid_o(alloc_rid_o), .tail_ptr_o(tail_ptr_o),
    .retire_i(retire_i), .c_rrrid_o(c_rrrid_o),
    .head_ptr_o(head_ptr_o), .head_valid_o(head_valid_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .flush_i(flush_i), .draining_o(draining_o)
  );

  always #5 clk = ~clk;

  // Model: ids in flight, oldest first; head/tail as unbounded sequence numbers.
  logic [5:0] exp_q[$];
  int         m_head, m_tail;
  bit         m_drain;
  int         n_checks = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit fl);
    return !m_drain && !fl && (64 - exp_q.size() >= 2);
  endfunction

  task automatic check_all(input bit fl);
    int cnt;
    cnt = exp_q.size();
    chk("alloc_ready", 32'(alloc_ready_o), 32'(model_ready(fl)));
    chk("alloc_rid", 32'(alloc_rid_o), 32'(((m_tail + 1) % 64) * 64 + m_tail % 64));
    chk("tail_ptr", 32'(tail_ptr_o), 32'(m_tail % 128));
    chk("c_rrrid", 32'(c_rrrid_o), 32'(((m_head + 1) % 64) * 64 + m_head % 64));
    chk("head_ptr", 32'(head_ptr_o), 32'(m_head % 128));
    chk("head_valid", 32'(head_valid_o), 32'({cnt >= 2, cnt >= 1}));
    chk("count", 32'(count_o), 32'(cnt));
    chk("empty", 32'(empty_o), 32'(cnt == 0));
    chk("full", 32'(full_o), 32'(cnt == 64));
    chk("draining", 32'(draining_o), 32'(m_drain));
  endtask

  task automatic model_advance(input logic [1:0] req, input logic [1:0] ret, input bit fl);
    int na, nr, cnt;
    cnt = exp_q.size();
    na  = model_ready(fl) ? int'(req[0]) + int'(req[1]) : 0;
    nr  = int'(ret[0]) + int'(ret[1]);
    if (nr > cnt) nr = cnt;
    repeat (nr) begin
      void'(exp_q.pop_front());
      m_head++;
    end
    repeat (na) begin
      exp_q.push_back(6'(m_tail % 64));
      m_tail++;
    end
    if (!m_drain && fl) m_drain = 1'b1;
    else if (m_drain && cnt == 0) m_drain = 1'b0;
  endtask

  // One clock: drive after negedge, check before posedge, leave inputs idle after.
  task automatic step(input logic [1:0] req, input logic [1:0] ret, input bit fl);
    @(negedge clk);
    alloc_req_i = req;
    retire_i    = ret;
    flush_i     = fl;
    #1;
    check_all(fl);
    model_advance(req, ret, fl);
    @(posedge clk);
    #1;
    alloc_req_i = '0;
    retire_i    = '0;
    flush_i     = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(alloc_ready_o), 32'd1);
    chk({tag, "_rid"}, 32'(alloc_rid_o), 32'h040);
    chk({tag, "_crid"}, 32'(c_rrrid_o), 32'h040);
    chk({tag, "_hvalid"}, 32'(head_valid_o), 32'd0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
    chk({tag, "_drain"}, 32'(draining_o), 32'd0);
    chk({tag, "_ptrs"}, 32'({head_ptr_o, tail_ptr_o}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst");
    exp_q.delete();
    m_head  = 0;
    m_tail  = 0;
    m_drain = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] prefix_tab [3];

  initial begin
    int r, a;
    prefix_tab[0] = 2'b00;
    prefix_tab[1] = 2'b01;
    prefix_tab[2] = 2'b11;

    do_reset();
    step(2'b00, 2'b00, 1'b0);

    // Fill the ROB two at a time.
    repeat (32) step(2'b11, 2'b00, 1'b0);
    chk("fill_tail", 32'(tail_ptr_o), 32'h40);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_ready", 32'(alloc_ready_o), 32'd0);
    step(2'b00, 2'b01, 1'b0);
    chk("free1_count", 32'(count_o), 32'd63);
    chk("free1_ready", 32'(alloc_ready_o), 32'd0);
    step(2'b00, 2'b01, 1'b0);
    chk("free2_ready", 32'(alloc_ready_o), 32'd1);

    // Walk both pointers to index 62 with the ROB empty, then wrap.
    do_reset();
    step(2'b11, 2'b00, 1'b0);
    repeat (30) step(2'b11, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    chk("pre_wrap_count", 32'(count_o), 32'd0);
    chk("pre_wrap_rid", 32'(alloc_rid_o), 32'({6'd63, 6'd62}));
    step(2'b11, 2'b00, 1'b0);
    chk("wrap_tail", 32'(tail_ptr_o), 32'h40);
    chk("wrap_crid", 32'(c_rrrid_o), 32'({6'd63, 6'd62}));
    chk("wrap_hvalid", 32'(head_valid_o), 32'd3);

    // Netted alloc and retire at count 10.
    repeat (4) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b11, 1'b0);
    chk("net_count", 32'(count_o), 32'd10);

    // Flush with a same-cycle allocation, then drain.
    repeat (5) step(2'b00, 2'b11, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    chk("flush_count", 32'(count_o), 32'd5);
    chk("flush_drain", 32'(draining_o), 32'd1);
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    chk("drained_count", 32'(count_o), 32'd0);
    chk("drained_still", 32'(draining_o), 32'd1);
    step(2'b00, 2'b00, 1'b0);
    chk("post_drain_ready", 32'(alloc_ready_o), 32'd1);
    chk("post_drain_rid", 32'(alloc_rid_o[0]), 32'(m_head % 64));

    // Excess retire at count 1.
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    chk("excess_count", 32'(count_o), 32'd0);
    chk("excess_empty", 32'(empty_o), 32'd1);

    // Flush while already empty still spends one cycle in DRAIN.
    step(2'b00, 2'b00, 1'b1);
    chk("empty_flush_drain", 32'(draining_o), 32'd1);
    step(2'b11, 2'b00, 1'b0);
    chk("empty_flush_back", 32'(draining_o), 32'd0);

    // Random prefix traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      a = $urandom_range(0, 2);
      r = $urandom_range(0, 2);
      if (r > exp_q.size()) r = exp_q.size();
      step(prefix_tab[a], prefix_tab[r], $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset in the middle of a drain.
    repeat (3) step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    m_head  = 0;
    m_tail  = 0;
    m_drain = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(2'b11, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wired_rob_ptr.md
Name: wired_rob_ptr

Overview:
- ROB allocation and retire pointer manager for the Wired ROB.
- Allocates up to two ROB ids per cycle to the dispatch (P) stage, producing the ROB write ids. Tracks the commit-side head and supplies the two C-stage read ids.
- Owns the occupancy counter and the backend-flush drain sequence. During a flush, commit walks and retires every remaining entry so the rename state is restored; no new allocation is allowed until the ROB is empty.

Parameters:
ROB_LEN  6  log2 of ROB depth (DEPTH = 1<<ROB_LEN = 64)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_req_i  in  2  dispatch slot requests; prefix form (req[1] implies req[0])
alloc_ready_o  out  1  allocation accepted this cycle
alloc_rid_o  out  2xROB_LEN  ids for slot0/slot1: tail, tail+1 (mod DEPTH)
tail_ptr_o  out  ROB_LEN+1  tail pointer with wrap bit (age compare)
retire_i  in  2  commit retires; prefix form; retire[0] retires the head
c_rrrid_o  out  2xROB_LEN  head, head+1 (mod DEPTH), to ROB C-stage read
head_ptr_o  out  ROB_LEN+1  head pointer with wrap bit
head_valid_o  out  2  bit0: count>=1; bit1: count>=2 (registered count)
count_o  out  ROB_LEN+1  occupied entries, 0..DEPTH
empty_o  out  1  count==0
full_o  out  1  count==DEPTH
flush_i  in  1  backend flush pulse
draining_o  out  1  FSM in DRAIN

Behaviour:
- Reset (async, rst_n=0): head=tail=0, count=0, state=NORMAL.
  - Outputs at reset: alloc_ready_o=1, alloc_rid_o={1,0}, c_rrrid_o={1,0}, head_valid_o=0, empty_o=1, full_o=0, draining_o=0.
  - Reset asserted mid-operation discards all state immediately.
- State: head_q, tail_q (ROB_LEN+1 bits each, wrap bit MSB), count_q (ROB_LEN+1 bits), state_q in {NORMAL, DRAIN}.
- alloc_ready_o is combinational: state_q==NORMAL & ~flush_i & (DEPTH - count_q >= 2).
  - It does not depend on alloc_req_i; this avoids a request-to-ready loop.
- Allocation:
  - n_alloc = ready ? popcount(alloc_req_i) : 0.
  - tail_next = tail_q + n_alloc, with natural wrap in ROB_LEN+1 bits.
  - alloc_rid_o is always driven from tail_q, whether or not a request is present.
- Retire:
  - n_retire = min(popcount(retire_i), count_q); excess retires are ignored (simulation assertion fires).
  - head_next = head_q + n_retire.
  - Retire is accepted in both NORMAL and DRAIN.
- count_next = count_q + n_alloc - n_retire.
  - Simultaneous alloc and retire are netted in the same cycle.
  - Space freed by a retire is visible to alloc_ready_o one cycle later, through count_q.
- Registered outputs: count_o, empty_o, full_o, head_valid_o and the pointer outputs all derive from the _q registers.
- Invariant: tail_q - head_q == count_q (mod 2^(ROB_LEN+1)).
  - full: pointers equal in index with wrap bits differing.
  - empty: pointers fully equal.
- FSM transitions:
  - NORMAL -> DRAIN on flush_i. An allocation presented in the flush cycle is rejected: ready is forced 0, tail unchanged.
  - DRAIN -> NORMAL when count_q==0. Minimum DRAIN residency is 1 cycle, including a flush when already empty.
  - flush_i while in DRAIN: ignored.
- Pointers are not reset by flush. They keep advancing via retires, so post-drain allocation continues from the current head==tail position.
- Illegal non-prefix inputs (req=2'b10, retire=2'b10) are treated as popcount. Assertions flag them.

Test Plan:
- Reset, then alloc_req_i=2'b11 for 32 cycles with no retire -> alloc_rid_o pairs (0,1),(2,3)...(62,63); count_o=64, full_o=1, alloc_ready_o=0; tail_ptr_o=7'h40.
- From full, retire_i=2'b01 for 1 cycle -> count_o=63 next cycle; alloc_ready_o stays 0 (free=1<2). A second retire gives free=2 -> ready=1.
- Wrap: head=62, tail=62, count 0; alloc 2'b11 -> alloc_rid_o=(62,63); next cycle tail_ptr_o=7'h40 (index 0, wrap bit set); c_rrrid_o=(62,63), head_valid_o=2'b11.
- Same-cycle alloc 2'b11 and retire 2'b11 at count=10 -> count stays 10; head and tail each advance by 2.
- Flush at count=5 with alloc_req_i=2'b11 in the same cycle -> alloc rejected, draining_o=1 next cycle; retire 2'b11,2'b11,2'b01 -> count 0. One cycle later NORMAL and alloc_ready_o=1, with alloc_rid_o equal to the head index.
- Retire_i=2'b11 at count=1 -> only 1 retired, count 0, assertion fires; async rst_n pulse mid-drain -> all outputs at reset values within the reset cycle.
